// File: rtl/ofmap_serializer.sv
// Wide-word to 32-bit ofmap stream serializer with a one-word skid (P) behind the shift holding register (H).
// Optional build macro OFMAP_RELU_EN clamps negative elements to zero as words are captured.

module ofmap_lane_relu #(
  parameter int W = 32
) (
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
`ifdef OFMAP_RELU_EN
  assign q_o = d_i[W-1] ? '0 : d_i;
`else
  assign q_o = d_i;
`endif
endmodule

module ofmap_serializer #(
  parameter int OFMAP_WIDTH = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [COUNT_WIDTH-1:0]             num_words,
  input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] wide_dat,
  input  logic                               wide_vld,
  output logic                               wide_rdy,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic                               busy,
  output logic                               done
);
  localparam int LW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;

  typedef logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] word_t;
  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q;
  word_t                  h_q, p_q, in_word, word_d;
  logic                   h_vld_q, p_vld_q, done_q;
  logic [LW-1:0]          lane_q;
  logic [COUNT_WIDTH-1:0] acc_cnt_q, tgt_q;
  logic                   accept, xfer, last_xfer, h_free;

  assign in_word = word_t'(wide_dat);

  for (genvar g = 0; g < ARRAY_WIDTH; g++) begin : g_lane
    ofmap_lane_relu #(.W(OFMAP_WIDTH)) u_lane (.d_i(in_word[g]), .q_o(word_d[g]));
  end

  // Ready depends only on registers; P being full is what throttles the source.
  assign wide_rdy  = (state_q == RUN) && !p_vld_q && (acc_cnt_q < tgt_q);
  assign accept    = wide_vld && wide_rdy;
  assign xfer      = h_vld_q && ofmap_rdy;
  assign last_xfer = xfer && (lane_q == LW'(ARRAY_WIDTH-1));
  assign h_free    = !h_vld_q || (last_xfer && !p_vld_q);

  assign ofmap_vld = h_vld_q;
  assign ofmap_dat = h_q[lane_q];
  assign busy      = (state_q == RUN);
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      h_q       <= '0;
      p_q       <= '0;
      h_vld_q   <= 1'b0;
      p_vld_q   <= 1'b0;
      lane_q    <= '0;
      acc_cnt_q <= '0;
      tgt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tgt_q     <= num_words;
            acc_cnt_q <= '0;
            lane_q    <= '0;
            if (num_words == '0) done_q  <= 1'b1;
            else                 state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) lane_q <= last_xfer ? '0 : lane_q + 1'b1;
          if (last_xfer) begin
            if (p_vld_q) begin
              h_q     <= p_q;
              p_vld_q <= 1'b0;
            end else if (!accept) begin
              h_vld_q <= 1'b0;
            end
          end
          // An accept never coincides with a P->H move since wide_rdy is low while P is full.
          if (accept) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
            if (h_free) begin
              h_q     <= word_d;
              h_vld_q <= 1'b1;
            end else begin
              p_q     <= word_d;
              p_vld_q <= 1'b1;
            end
          end
          if (last_xfer && !p_vld_q && (acc_cnt_q == tgt_q)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofmap_serializer.sv
// Self-checking bench for ofmap_serializer: random wide words checked against a lane-order queue model.
module tb_ofmap_serializer;
  localparam int OW = 32;
  localparam int AW = 4;
  localparam int CW = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wide_vld = 1'b0, ofmap_rdy = 1'b0;
  logic [CW-1:0]    num_words = '0;
  logic [AW*OW-1:0] wide_dat = '0;
  logic             wide_rdy, ofmap_vld, busy, done;
  logic [OW-1:0]    ofmap_dat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ofmap_serializer #(.OFMAP_WIDTH(OW), .ARRAY_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .wide_dat(wide_dat), .wide_vld(wide_vld), .wide_rdy(wide_rdy),
    .ofmap_dat(ofmap_dat), .ofmap_vld(ofmap_vld), .ofmap_rdy(ofmap_rdy),
    .busy(busy), .done(done)
  );

  logic [AW*OW-1:0] src[$];
  logic [OW-1:0]    exp_q[$], got_q[$];
  int src_idx, acc_words, done_cnt, stall_err, p_err, bubble, cyc, rdy_mode;
  int start_cyc, done_cyc, first_out_cyc, last_xfer_cyc;
  bit p_seen, vld_seen, busy_seen, stall_prev, gaps, start_req;
  logic [OW-1:0] stall_dat;

  function automatic logic [OW-1:0] relu_mdl(input logic [OW-1:0] x);
`ifdef OFMAP_RELU_EN
    return ($signed(x) < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic gen_src(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back({$urandom, $urandom, $urandom, $urandom});
  endtask

  // One cycle: drive at the falling edge, then observe what the next rising edge will do.
  task automatic step();
    @(negedge clk);
    start = start_req;
    num_words = CW'(src.size());
    start_req = 1'b0;
    if (src_idx < src.size() && (!gaps || $urandom_range(3) != 0)) begin
      wide_vld = 1'b1;
      wide_dat = src[src_idx];
    end else begin
      wide_vld = 1'b0;
    end
    case (rdy_mode)
      0:       ofmap_rdy = 1'b1;
      1:       ofmap_rdy = 1'($urandom_range(1));
      default: ofmap_rdy = (cyc % 3 == 0);
    endcase
    #1;
    if (start) start_cyc = cyc;
    if (busy) busy_seen = 1'b1;
    if (ofmap_vld) begin
      vld_seen = 1'b1;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (stall_prev && (!ofmap_vld || ofmap_dat !== stall_dat)) stall_err++;
    stall_prev = ofmap_vld && !ofmap_rdy;
    stall_dat  = ofmap_dat;
    if (acc_words - got_q.size() / AW >= 2) begin
      p_seen = 1'b1;
      if (wide_rdy) p_err++;
    end
    if (rdy_mode == 0 && !gaps && got_q.size() > 0 && got_q.size() < exp_q.size() && !ofmap_vld)
      bubble++;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (ofmap_vld && ofmap_rdy) begin
      got_q.push_back(ofmap_dat);
      last_xfer_cyc = cyc;
    end
    if (wide_vld && wide_rdy) begin
      acc_words++;
      src_idx++;
    end
    cyc++;
  endtask

  task automatic clear_obs();
    logic [AW*OW-1:0] w;
    got_q.delete();
    exp_q.delete();
    foreach (src[i]) begin
      w = src[i];
      for (int l = 0; l < AW; l++) exp_q.push_back(relu_mdl(w[l*OW +: OW]));
    end
    src_idx = 0; acc_words = 0; done_cnt = 0; stall_err = 0; p_err = 0; bubble = 0;
    start_cyc = -1; done_cyc = -1; first_out_cyc = -1; last_xfer_cyc = -1;
    p_seen = 0; vld_seen = 0; busy_seen = 0; stall_prev = 0;
  endtask

  task automatic run_layer(input int mode, input bit g);
    rdy_mode = mode;
    gaps = g;
    clear_obs();
    start_req = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    repeat (3) step();
  endtask

  task automatic test_reset();
    #1;
    total++; if (wide_rdy !== 1'b0) begin bad++; $display("FAIL rst_wide_rdy: got %b want 0", wide_rdy); end
    total++; if (ofmap_vld !== 1'b0) begin bad++; $display("FAIL rst_ofmap_vld: got %b want 0", ofmap_vld); end
    total++; if (ofmap_dat !== '0) begin bad++; $display("FAIL rst_ofmap_dat: got %h want 0", ofmap_dat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    src.delete();
    src.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    run_layer(0, 0);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL single_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== OW'(i + 1)) begin
        bad++; $display("FAIL single_lane%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, i + 1);
      end
    end
    total++; if (first_out_cyc != start_cyc + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", first_out_cyc - start_cyc, 2); end
    total++; if (last_xfer_cyc != first_out_cyc + 3) begin bad++; $display("FAIL single_span: got %0d want 3", last_xfer_cyc - first_out_cyc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL single_done_time: got %0d want %0d", done_cyc, last_xfer_cyc + 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    gen_src(3);
    run_layer(0, 0);
    total++; if (got_q.size() != 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_elem%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    total++; if (bubble != 0) begin bad++; $display("FAIL b2b_bubbles: got %0d want 0", bubble); end
    total++; if (last_xfer_cyc != first_out_cyc + 11) begin bad++; $display("FAIL b2b_span: got %0d want 11", last_xfer_cyc - first_out_cyc); end
    total++; if (acc_words != 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", acc_words); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    for (int m = 2; m >= 1; m--) begin
      gen_src(5);
      run_layer(m, (m == 1));
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp%0d_count: got %0d want %0d", m, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL bp%0d_elem%0d: got %h want %h", m, i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
        end
      end
      total++; if (stall_err != 0) begin bad++; $display("FAIL bp%0d_stall_stable: got %0d changes want 0", m, stall_err); end
      total++; if (p_err != 0) begin bad++; $display("FAIL bp%0d_rdy_when_full: got %0d want 0", m, p_err); end
      total++; if (acc_words != 5) begin bad++; $display("FAIL bp%0d_accepts: got %0d want 5", m, acc_words); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL bp%0d_done_cnt: got %0d want 1", m, done_cnt); end
      if (m == 2) begin
        total++; if (!p_seen) begin bad++; $display("FAIL bp2_skid_used: got 0 want 1"); end
      end
    end
  endtask

  task automatic test_zero();
    src.delete();
    run_layer(0, 0);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cyc != start_cyc + 1) begin bad++; $display("FAIL zero_done_time: got %0d want %0d", done_cyc, start_cyc + 1); end
    total++; if (vld_seen) begin bad++; $display("FAIL zero_ofmap_vld: got 1 want 0"); end
    total++; if (busy_seen) begin bad++; $display("FAIL zero_busy: got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    int d;
    src.delete();
    src.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    rdy_mode = 0; gaps = 0;
    clear_obs();
    start_req = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 2; i++) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wide_vld = 1'b0;
    #1;
    total++; if (ofmap_vld !== 1'b0) begin bad++; $display("FAIL rmid_ofmap_vld: got %b want 0", ofmap_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (wide_rdy !== 1'b0) begin bad++; $display("FAIL rmid_wide_rdy: got %b want 0", wide_rdy); end
    d = 0;
    repeat (4) begin @(negedge clk); if (done) d++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) d++; end
    total++; if (d != 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", d); end
    run_layer(0, 0);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL rmid_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== OW'(i + 1)) begin
        bad++; $display("FAIL rmid_lane%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, i + 1);
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rmid_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_relu();
    logic [OW-1:0] want[4];
`ifdef OFMAP_RELU_EN
    want[0] = 32'd0; want[1] = 32'd7; want[2] = 32'd0; want[3] = 32'd0;
`else
    want[0] = 32'hFFFF_FFFB; want[1] = 32'd7; want[2] = 32'hFFFF_FFFF; want[3] = 32'd0;
`endif
    src.delete();
    src.push_back({32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFB});
    run_layer(0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        bad++; $display("FAIL relu_lane%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
      end
    end
    gen_src(4);
    run_layer(1, 1);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL relu_rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL relu_rand%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  initial begin
    cyc = 0;
    start_req = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_relu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
